serial_sub: RTL



---
 rtl/sub_pkg.sv | 12 +
 rtl/full_sub.sv | 20 ++
 rtl/serial_sub.sv | 99 +++++++++
 3 files changed

// File: rtl/sub_pkg.sv
// Shared types and constants for the bit-serial subtractor.
package sub_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int SUB_W_DEF = 8;

endpackage

// File: rtl/full_sub.sv
// One-bit full subtractor: x - y - bi, built from two half-subtractor stages.
module full_sub (
    input  logic x,
    input  logic y,
    input  logic bi,
    output logic d,
    output logic bo
);

    logic d1;
    logic b1;
    logic b2;

    assign d1 = x ^ y;
    assign b1 = ~x & y;
    assign d  = d1 ^ bi;
    assign b2 = ~d1 & bi;
    assign bo = b1 | b2;

endmodule

// File: rtl/serial_sub.sv
// Bit-serial unsigned subtractor: d = (a - b) mod 2^W, one bit per clock, LSB first,
// with a start/busy/done handshake.
module serial_sub
    import sub_pkg::*;
#(
    parameter int W = SUB_W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         start,
    input  logic [W-1:0] a,
    input  logic [W-1:0] b,
    output logic         busy,
    output logic         done,
    output logic [W-1:0] d,
    output logic         bout
);

    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    state_t        state_q;
    logic [W-1:0]  sa_q;
    logic [W-1:0]  sb_q;
    logic [W-1:0]  sr_q;
    logic          br_q;
    logic [CW-1:0] cnt_q;
    logic [W-1:0]  d_q;
    logic          bout_q;
    logic          done_q;

    logic          x;
    logic          bo;
    logic [W-1:0]  sr_d;

    full_sub u_cell (
        .x  (sa_q[0]),
        .y  (sb_q[0]),
        .bi (br_q),
        .d  (x),
        .bo (bo)
    );

    assign sr_d = {x, sr_q[W-1:1]};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            sa_q    <= '0;
            sb_q    <= '0;
            sr_q    <= '0;
            br_q    <= 1'b0;
            cnt_q   <= '0;
            d_q     <= '0;
            bout_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (start) begin
                        sa_q    <= a;
                        sb_q    <= b;
                        br_q    <= 1'b0;
                        cnt_q   <= '0;
                        state_q <= RUN;
                    end
                end
                RUN: begin
                    sa_q <= sa_q >> 1;
                    sb_q <= sb_q >> 1;
                    sr_q <= sr_d;
                    br_q <= bo;
                    // Results are published only on the final bit so d/bout never show partial values.
                    if (cnt_q == LAST) begin
                        d_q     <= sr_d;
                        bout_q  <= bo;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end else begin
                        cnt_q <= cnt_q + CW'(1);
                    end
                end
                DONE: begin
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
                default: begin
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign busy = (state_q != IDLE);
    assign done = done_q;
    assign d    = d_q;
    assign bout = bout_q;

endmodule
